seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Memory-mapped, parametrised multiplexed seven-segment display controller, the successor to the fixed four-digit scan logic in the SoC top level. It holds per-digit hex values, decimal-point and blanking masks, and a control register, all written over the core's data-memory write port. It time-multiplexes `NUM_DIGITS` common-anode digits with programmable refresh period, PWM brightness and leading-zero suppression. It sits beside data memory at a decoded address window and drives the board anodes and cathodes directly.

## Interface
- `NUM_DIGITS`, 4: digits driven, 1..8.
- `REFRESH_BITS`, 18: width of the per-digit dwell counter; dwell = 2^REFRESH_BITS cycles; must be >= 4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `we`  in  1  write strobe, sampled on rising `clk`.
- `addr`  in  2  word address within the block window.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data for `addr`.
- `an`  out  NUM_DIGITS  anodes, active-low, bit 0 = rightmost digit.
- `seg`  out  7  cathodes GFEDCBA, active-low.
- `dp`  out  1  decimal point cathode, active-low.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Registers (word addresses):
  - 0 DIGITS: nibble i = `wdata[4i+3:4i]` for digit i; bits above 4*NUM_DIGITS ignored; reset 0.
  - 1 CTRL: bit0 `enable` (reset 1), bit1 `lz_blank` (reset 0), bits[7:4] `bright` (reset 15); other bits read 0.
  - 2 DPMASK: bits[NUM_DIGITS-1:0], 1 lights that digit's point; reset 0.
  - 3 BLANK: bits[NUM_DIGITS-1:0], 1 forces that digit dark; reset 0.
- Writes take effect on the `clk` edge where `we`=1. `rdata` updates every cycle to the register at `addr` (1-cycle latency), zero-extended.
- Scan: `dwell_cnt` (REFRESH_BITS wide) increments each cycle while `enable`=1; on wrap from all-ones, `digit_idx` advances; `digit_idx` wraps NUM_DIGITS-1 -> 0 and `frame_tick` pulses in the cycle after that wrap.
- Brightness: with top4 = `dwell_cnt[REFRESH_BITS-1 -: 4]`, the digit is lit only while top4 <= `bright`; `bright`=15 is full on, `bright`=0 is 1/16 duty.
- Leading-zero blank (`lz_blank`=1): digit i is dark if it and every higher digit hold nibble 0; digit 0 is never blanked by this rule.
- A digit is lit when enable, brightness window, not BLANK, and not leading-zero-blanked all hold; then `an` has only bit `digit_idx` low, `seg` = hex glyph of the nibble (0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000, A -> 0001000, b -> 0000011, C -> 0100111, d -> 0100001, E -> 0000110, F -> 0001110), `dp` = ~DPMASK[idx]. Otherwise `an` all 1, `seg`=1111111, `dp`=1.
- `enable` 0: `dwell_cnt` and `digit_idx` held at 0, outputs dark, no `frame_tick`. Re-enable restarts at digit 0, count 0.

## Timing
- Reset (asynchronous, `reset`=0): all registers to reset values; `an` all 1, `seg`=1111111, `dp`=1, `frame_tick`=0, `rdata`=0, `dwell_cnt`=0, `digit_idx`=0, immediately without a clock edge.
- `an`, `seg`, `dp`, `frame_tick` registered: reflect state and registers one cycle after the edge that changed them.
- Register write to visible change: 2 edges worst case (write edge, output edge).
- Frame period = NUM_DIGITS * 2^REFRESH_BITS cycles; `frame_tick` spacing exactly that while enabled.
- Write to CTRL clearing `enable` mid-dwell: counters zero on the write edge, outputs dark on the following edge.
- Simultaneous write and scan advance: scan advances normally; new value used from the next output edge.

## Test plan
- Reset: hold `reset`=0 mid-scan with no clock -> `an`=1111, `seg`=1111111, `dp`=1, `rdata`=0; release -> CTRL reads 0x000000F1.
- NUM_DIGITS=4, REFRESH_BITS=4, write DIGITS=0x1234 -> 16 cycles `an`=1110 `seg`=0011001, then `an`=1101 `seg`=0110000, 1011/0100100, 0111/1111001; `frame_tick` every 64 cycles.
- CTRL `bright`=7, enable=1 -> each digit lit for 8 of its 16 dwell cycles, dark for the remaining 8.
- DIGITS=0x0040, `lz_blank`=1, DPMASK=0x2 -> digits 3,2 dark; digit 1 `seg`=0011001 with `dp`=0; digit 0 `seg`=1000000, `dp`=1.
- BLANK=0x1 plus DIGITS=0xFFFF -> digit 0 slot `an`=1111; other slots `seg`=0001110.
- Write CTRL=0xF0 mid-dwell -> outputs dark next cycle, no `frame_tick`; write CTRL=0xF1 -> scan resumes at `an`=1110 with full 16-cycle dwell.

Source files
------------

// File: rtl/seg7_bus_if.sv
// Register-window bus for the seven-segment scan controller:
// write strobe, word address, write data and registered read data.
interface seg7_bus_if;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output we, output addr, output wdata, input rdata);
   modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment controller with programmable refresh,
// PWM brightness, per-digit decimal points, blanking and leading-zero suppression.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_BITS = 18
) (
   input  logic                  clk,
   input  logic                  reset,
   seg7_bus_if.slave             bus,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   localparam logic [1:0] A_DIGITS = 2'd0;
   localparam logic [1:0] A_CTRL   = 2'd1;
   localparam logic [1:0] A_DPMASK = 2'd2;
   localparam logic [1:0] A_BLANK  = 2'd3;

   // Programmable registers
   logic [NUM_DIGITS-1:0][3:0] digits;
   logic                       enable;
   logic                       lz_blank;
   logic [3:0]                 bright;
   logic [NUM_DIGITS-1:0]      dp_mask;
   logic [NUM_DIGITS-1:0]      blank_mask;

   // Scan state
   logic [REFRESH_BITS-1:0]    dwell_cnt;
   logic [IDX_W-1:0]           digit_idx;

   logic [31:0]                rd_next;
   logic                       scan_stop;
   logic                       dwell_max;
   logic                       at_last;
   logic [3:0]                 top4;
   logic [3:0]                 nib;
   logic [NUM_DIGITS-1:0]      zero_from;
   logic                       lz_dark;
   logic                       lit;
   logic [NUM_DIGITS-1:0]      an_sel;
   logic                       unused_wdata;

   assign unused_wdata = ^bus.wdata;

   // Hex glyphs, GFEDCBA, active-low
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b0100111;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digits     <= '0;
         enable     <= 1'b1;
         lz_blank   <= 1'b0;
         bright     <= 4'hF;
         dp_mask    <= '0;
         blank_mask <= '0;
      end else if (bus.we) begin
         case (bus.addr)
            A_DIGITS: digits <= bus.wdata[4*NUM_DIGITS-1:0];
            A_CTRL: begin
               enable   <= bus.wdata[0];
               lz_blank <= bus.wdata[1];
               bright   <= bus.wdata[7:4];
            end
            A_DPMASK: dp_mask    <= bus.wdata[NUM_DIGITS-1:0];
            default:  blank_mask <= bus.wdata[NUM_DIGITS-1:0];
         endcase
      end
   end

   always_comb begin
      rd_next = '0;
      case (bus.addr)
         A_DIGITS: rd_next[4*NUM_DIGITS-1:0] = digits;
         A_CTRL:   rd_next[7:0]              = {bright, 2'b00, lz_blank, enable};
         A_DPMASK: rd_next[NUM_DIGITS-1:0]   = dp_mask;
         default:  rd_next[NUM_DIGITS-1:0]   = blank_mask;
      endcase
   end

   // A write clearing enable zeroes the counters on that same edge.
   assign scan_stop = !enable || (bus.we && (bus.addr == A_CTRL) && !bus.wdata[0]);
   assign dwell_max = &dwell_cnt;
   assign at_last   = (digit_idx == LAST_IDX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dwell_cnt <= '0;
         digit_idx <= '0;
      end else if (scan_stop) begin
         dwell_cnt <= '0;
         digit_idx <= '0;
      end else begin
         dwell_cnt <= dwell_cnt + 1'b1;
         if (dwell_max) begin
            digit_idx <= at_last ? '0 : digit_idx + 1'b1;
         end
      end
   end

   // zero_from[i]: digit i and every digit above it hold nibble 0
   always_comb begin
      logic acc;
      zero_from = '0;
      acc       = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc          = acc && (digits[i] == 4'h0);
         zero_from[i] = acc;
      end
   end

   assign top4    = dwell_cnt[REFRESH_BITS-1 -: 4];
   assign nib     = digits[digit_idx];
   assign lz_dark = lz_blank && (digit_idx != '0) && zero_from[digit_idx];
   assign lit     = enable && (top4 <= bright) && !blank_mask[digit_idx] && !lz_dark;
   assign an_sel  = NUM_DIGITS'(1) << digit_idx;

   // Registered display outputs and read data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an         <= '1;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
         bus.rdata  <= '0;
      end else begin
         if (lit) begin
            an  <= ~an_sel;
            seg <= glyph(nib);
            dp  <= ~dp_mask[digit_idx];
         end else begin
            an  <= '1;
            seg <= 7'b1111111;
            dp  <= 1'b1;
         end
         frame_tick <= !scan_stop && dwell_max && at_last;
         bus.rdata  <= rd_next;
      end
   end

endmodule
